// File: rtl/eq_tap_sequencer_if.sv
// Config write port, load request and tap-stream handshake of the EQ tap sequencer.
interface eq_tap_sequencer_if #(
    parameter int unsigned NUM_BANDS = 4,
    parameter int unsigned COEFF_W   = 16,
    parameter int unsigned GAIN_W    = 2
);
    logic                        cfgWe;
    logic [7:0]                  cfgAddr;
    logic [COEFF_W-1:0]          cfgData;
    logic                        load;
    logic [NUM_BANDS*GAIN_W-1:0] eqVal;
    logic                        tapValid;
    logic                        tapReady;
    logic [COEFF_W-1:0]          tapCoeff;
    logic [7:0]                  tapNum;
    logic                        tapLast;
    logic                        busy;

    // Sequencer side: sources the tap stream.
    modport master (
        input  cfgWe, cfgAddr, cfgData, load, eqVal, tapReady,
        output tapValid, tapCoeff, tapNum, tapLast, busy
    );

    // Control / filter side.
    modport slave (
        output cfgWe, cfgAddr, cfgData, load, eqVal, tapReady,
        input  tapValid, tapCoeff, tapNum, tapLast, busy
    );
endinterface

// File: rtl/eq_tap_sequencer.sv
// Equalizer tap-coefficient sequencer: base-coefficient RAM, per-band gain scaling
// with floor shift and saturation, streamed over valid/ready with one queued load.
module eq_tap_sequencer #(
    parameter int unsigned NUM_BANDS     = 4,
    parameter int unsigned TAPS_PER_BAND = 4,
    parameter int unsigned COEFF_W       = 16,
    parameter int unsigned GAIN_W        = 2
) (
    input logic                clk,
    input logic                reset,
    eq_tap_sequencer_if.master bus
);
    localparam int unsigned NUM_TAPS = NUM_BANDS * TAPS_PER_BAND;
    localparam int unsigned ADDR_W   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int unsigned PROD_W   = COEFF_W + GAIN_W + 1;
    localparam int unsigned EQ_W     = NUM_BANDS * GAIN_W;
    localparam logic [7:0]  LAST_TAP = 8'(NUM_TAPS - 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(GAIN_W+2){1'b0}}, {(COEFF_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(GAIN_W+2){1'b1}}, {(COEFF_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

    state_t                    state;
    logic [EQ_W-1:0]           gain_q;
    logic                      pend;
    logic [EQ_W-1:0]           pend_gain;
    logic [7:0]                rd_num;
    logic [COEFF_W-1:0]        mem [NUM_TAPS];
    logic signed [COEFF_W-1:0] rd_data;

    logic [GAIN_W-1:0]         rd_gain_c;
    logic signed [PROD_W-1:0]  base_ext_c;
    logic signed [PROD_W-1:0]  gain_ext_c;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [PROD_W-1:0]  shifted_c;
    logic [COEFF_W-1:0]        scaled_c;
    logic                      last_accept_c;
    logic                      advance_c;
    logic                      rd_en_c;
    logic [ADDR_W-1:0]         rd_addr_c;
    logic                      cfg_wr_c;

    // Gain code of the band owning the tap currently held in the read stage.
    always_comb begin
        rd_gain_c = '0;
        for (int unsigned b = 0; b < NUM_BANDS; b++) begin
            if ((32'(rd_num) / TAPS_PER_BAND) == b) begin
                rd_gain_c = gain_q[b*GAIN_W +: GAIN_W];
            end
        end
    end

    // Scale base by unsigned gain, floor-shift by unity, clamp to coefficient range.
    always_comb begin
        base_ext_c = PROD_W'($signed(rd_data));
        gain_ext_c = PROD_W'({1'b0, rd_gain_c});
        prod_c     = base_ext_c * gain_ext_c;
        shifted_c  = prod_c >>> (GAIN_W - 1);
        if (shifted_c > SAT_MAX) begin
            scaled_c = {1'b0, {(COEFF_W-1){1'b1}}};
        end else if (shifted_c < SAT_MIN) begin
            scaled_c = {1'b1, {(COEFF_W-1){1'b0}}};
        end else begin
            scaled_c = shifted_c[COEFF_W-1:0];
        end
    end

    // Handshake decode: output slot refills whenever empty or being accepted (no bubble).
    always_comb begin
        last_accept_c = (state == STREAM) && bus.tapValid && bus.tapReady && bus.tapLast;
        advance_c     = (state == STREAM) && (!bus.tapValid || (bus.tapReady && !bus.tapLast));
        rd_en_c       = (state == FETCH) || (advance_c && (rd_num != LAST_TAP));
        rd_addr_c     = (state == FETCH) ? '0 : ADDR_W'(rd_num + 8'd1);
        cfg_wr_c      = bus.cfgWe && !bus.busy && (32'(bus.cfgAddr) < NUM_TAPS);
    end

    // Base-coefficient RAM with synchronous read; contents survive reset.
    always_ff @(posedge clk) begin
        if (cfg_wr_c) begin
            mem[bus.cfgAddr[ADDR_W-1:0]] <= bus.cfgData;
        end
        if (rd_en_c) begin
            rd_data <= mem[rd_addr_c];
        end
    end

    // Sequencer FSM with registered stream outputs and a single pending-load slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            gain_q       <= '0;
            pend         <= 1'b0;
            pend_gain    <= '0;
            rd_num       <= '0;
            bus.tapValid <= 1'b0;
            bus.tapCoeff <= '0;
            bus.tapNum   <= '0;
            bus.tapLast  <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        gain_q   <= bus.eqVal;
                        rd_num   <= '0;
                        state    <= FETCH;
                        bus.busy <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= STREAM;
                    if (bus.load) begin
                        pend      <= 1'b1;
                        pend_gain <= bus.eqVal;
                    end
                end
                STREAM: begin
                    if (last_accept_c) begin
                        bus.tapValid <= 1'b0;
                        bus.tapLast  <= 1'b0;
                        rd_num       <= '0;
                        pend         <= 1'b0;
                        if (bus.load) begin
                            gain_q <= bus.eqVal;
                            state  <= FETCH;
                        end else if (pend) begin
                            gain_q <= pend_gain;
                            state  <= FETCH;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        if (bus.load) begin
                            pend      <= 1'b1;
                            pend_gain <= bus.eqVal;
                        end
                        if (advance_c) begin
                            bus.tapValid <= 1'b1;
                            bus.tapCoeff <= scaled_c;
                            bus.tapNum   <= rd_num;
                            bus.tapLast  <= (rd_num == LAST_TAP);
                            if (rd_num != LAST_TAP) begin
                                rd_num <= rd_num + 8'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eq_tap_sequencer.sv
// Self-checking bench for eq_tap_sequencer: reference model + scoreboard, vector tables, corner sequences.
module tb_eq_tap_sequencer;
    localparam int NB  = 4;
    localparam int TPB = 4;
    localparam int CW  = 16;
    localparam int GW  = 2;
    localparam int NT  = NB * TPB;

    logic clk = 1'b0;
    logic reset;

    eq_tap_sequencer_if #(.NUM_BANDS(NB), .COEFF_W(CW), .GAIN_W(GW)) bus ();

    eq_tap_sequencer #(.NUM_BANDS(NB), .TAPS_PER_BAND(TPB), .COEFF_W(CW), .GAIN_W(GW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int num; int coeff; int last; } tap_t;
    typedef struct { logic [15:0] base; logic [7:0] eq; logic [15:0] expv; } sat_vec_t;

    tap_t       exp_q[$];
    int         acc_q[$];
    int         m_mem[NT];
    bit         m_active;
    bit         m_pend;
    logic [7:0] m_pend_eq;
    int         m_lat;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Reference arithmetic: base*gain / 2^(GW-1) rounded toward -inf, then clamped.
    function automatic int ref_scale(input int base, input int gain);
        int p;
        int d;
        int q;
        p = base * gain;
        d = 1 << (GW - 1);
        q = p / d;
        if ((p % d) != 0 && p < 0) q -= 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q & 32'h0000_FFFF;
    endfunction

    task automatic m_start(input logic [7:0] eq);
        m_active = 1'b1;
        m_lat    = 3;
        for (int t = 0; t < NT; t++) begin
            tap_t e;
            int   g;
            g       = (int'(eq) >> ((t / TPB) * GW)) & ((1 << GW) - 1);
            e.num   = t;
            e.coeff = ref_scale(m_mem[t], g);
            e.last  = (t == NT - 1) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    // One clock: update the model from the inputs seen at this edge, then check outputs.
    task automatic step();
        tap_t f;
        if (bus.cfgWe && !(m_active || m_pend) && int'(bus.cfgAddr) < NT)
            m_mem[int'(bus.cfgAddr)] = int'($signed(bus.cfgData));
        if (bus.load) begin
            if (m_active) begin
                m_pend    = 1'b1;
                m_pend_eq = bus.eqVal;
            end else begin
                m_start(bus.eqVal);
            end
        end
        if (bus.tapValid && bus.tapReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_accept actual_num=%0d required=none", bus.tapNum);
            end else begin
                f = exp_q.pop_front();
                acc_q.push_back(int'(bus.tapCoeff));
                if (f.last != 0) begin
                    m_active = 1'b0;
                    if (m_pend) begin
                        m_pend = 1'b0;
                        m_start(m_pend_eq);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
        bus.cfgWe = 1'b0;
        if (m_lat > 0) m_lat--;
        chk("busy", int'(bus.busy), int'(m_active || m_pend));
        chk("tapValid", int'(bus.tapValid), int'(m_active && m_lat == 0));
        if (bus.tapValid && exp_q.size() > 0) begin
            chk("tapNum", int'(bus.tapNum), exp_q[0].num);
            chk("tapCoeff", int'(bus.tapCoeff), exp_q[0].coeff);
            chk("tapLast", int'(bus.tapLast), exp_q[0].last);
        end
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while ((m_active || m_pend || bus.tapValid) && n < 400) begin
            bus.tapReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        chk("drain_done", int'(m_active || m_pend || bus.tapValid), 0);
        bus.tapReady = 1'b1;
    endtask

    task automatic write(input int a, input logic [15:0] d);
        bus.cfgWe   = 1'b1;
        bus.cfgAddr = 8'(a);
        bus.cfgData = d;
        step();
    endtask

    task automatic run_seq(input logic [7:0] eq, input bit rnd);
        acc_q.delete();
        bus.eqVal = eq;
        bus.load  = 1'b1;
        step();
        drain(rnd);
    endtask

    task automatic wait_tap(input int num);
        int n;
        n = 0;
        while (!(bus.tapValid && int'(bus.tapNum) == num) && n < 60) begin
            step();
            n++;
        end
        chk("reach_tap", int'(bus.tapValid && int'(bus.tapNum) == num), 1);
    endtask

    int       basic_exp[NT];
    int       unity_half[4];
    sat_vec_t sv[7];

    initial begin
        basic_exp  = '{0, 0, 0, 0, 2, 2, 3, 3, 6, 7, 9, 10, 6, 7, 9, 10};
        unity_half = '{2, 2, 3, 3};
        sv[0] = '{16'h7000, 8'h03, 16'h7FFF};
        sv[1] = '{16'h9000, 8'h03, 16'h8000};
        sv[2] = '{16'hFFFB, 8'h03, 16'hFFF8};
        sv[3] = '{16'hFFFB, 8'h01, 16'hFFFD};
        sv[4] = '{16'h1234, 8'h02, 16'h1234};
        sv[5] = '{16'h8000, 8'h02, 16'h8000};
        sv[6] = '{16'h7FFF, 8'h00, 16'h0000};

        m_active = 1'b0; m_pend = 1'b0; m_pend_eq = '0; m_lat = 0;
        for (int t = 0; t < NT; t++) m_mem[t] = 0;
        reset = 1'b1;
        bus.cfgWe = 1'b0; bus.cfgAddr = '0; bus.cfgData = '0;
        bus.load = 1'b0; bus.eqVal = '0; bus.tapReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tapValid", int'(bus.tapValid), 0);
        chk("rst_tapCoeff", int'(bus.tapCoeff), 0);
        chk("rst_tapNum", int'(bus.tapNum), 0);
        chk("rst_tapLast", int'(bus.tapLast), 0);
        chk("rst_busy", int'(bus.busy), 0);
        reset = 1'b0;

        for (int t = 0; t < NT; t++) write(t, 16'(4 + (t % 4)));

        // Basic stream, ready held high.
        run_seq(8'hF4, 1'b0);
        chk("basic_count", acc_q.size(), NT);
        for (int t = 0; t < NT; t++)
            chk("basic_coeff", (t < acc_q.size()) ? acc_q[t] : -1, basic_exp[t]);

        // Backpressure: same coefficients with random stalls.
        run_seq(8'hF4, 1'b1);
        chk("bp_count", acc_q.size(), NT);
        for (int t = 0; t < NT; t++)
            chk("bp_coeff", (t < acc_q.size()) ? acc_q[t] : -1, basic_exp[t]);

        // Saturation / floor table on tap 0.
        for (int i = 0; i < 7; i++) begin
            write(0, sv[i].base);
            run_seq(sv[i].eq, 1'b0);
            chk("sat_tap0", (acc_q.size() > 0) ? acc_q[0] : -1, int'(sv[i].expv));
        end
        write(0, 16'd4);

        // Queued loads: AA overwritten by 55, F4 sequence finishes first.
        acc_q.delete();
        bus.eqVal = 8'hF4; bus.load = 1'b1; step();
        wait_tap(5);
        bus.eqVal = 8'hAA; bus.load = 1'b1; step();
        wait_tap(9);
        bus.eqVal = 8'h55; bus.load = 1'b1; step();
        drain(1'b0);
        chk("queue_count", acc_q.size(), 2 * NT);
        for (int t = 0; t < NT; t++) begin
            chk("queue_first", (t < acc_q.size()) ? acc_q[t] : -1, basic_exp[t]);
            chk("queue_second", (NT + t < acc_q.size()) ? acc_q[NT + t] : -1, unity_half[t % 4]);
        end

        // Load in the same cycle as the last-tap accept.
        acc_q.delete();
        bus.eqVal = 8'hF4; bus.load = 1'b1; step();
        wait_tap(NT - 1);
        bus.eqVal = 8'hAA; bus.load = 1'b1; step();
        drain(1'b0);
        chk("lastload_count", acc_q.size(), 2 * NT);
        chk("lastload_tap4", (NT + 4 < acc_q.size()) ? acc_q[NT + 4] : -1, 4);

        // Write and load together in IDLE: tap 0 sees the new value.
        acc_q.delete();
        bus.cfgWe = 1'b1; bus.cfgAddr = 8'd0; bus.cfgData = 16'd100;
        bus.eqVal = 8'hFF; bus.load = 1'b1;
        step();
        drain(1'b0);
        chk("wr_load_tap0", (acc_q.size() > 0) ? acc_q[0] : -1, 150);
        write(0, 16'd4);

        // Config lockout while busy, out-of-range write in IDLE.
        bus.eqVal = 8'hF4; bus.load = 1'b1; step();
        step();
        write(3, 16'h1234);
        drain(1'b0);
        write(20, 16'h7777);
        run_seq(8'hAA, 1'b0);
        chk("lockout_tap3", (acc_q.size() > 3) ? acc_q[3] : -1, 7);
        chk("range_tap4", (acc_q.size() > 4) ? acc_q[4] : -1, 4);

        // Asynchronous reset during tap 7.
        bus.eqVal = 8'hF4; bus.load = 1'b1; step();
        wait_tap(7);
        #1 reset = 1'b1;
        #1;
        chk("arst_tapValid", int'(bus.tapValid), 0);
        chk("arst_tapCoeff", int'(bus.tapCoeff), 0);
        chk("arst_tapNum", int'(bus.tapNum), 0);
        chk("arst_tapLast", int'(bus.tapLast), 0);
        chk("arst_busy", int'(bus.busy), 0);
        #2 reset = 1'b0;
        exp_q.delete();
        m_active = 1'b0; m_pend = 1'b0; m_lat = 0;
        @(posedge clk);
        #1;
        repeat (8) step();
        run_seq(8'hF4, 1'b1);
        chk("post_rst_count", acc_q.size(), NT);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.tapReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                bus.load  = 1'b1;
                bus.eqVal = 8'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                bus.cfgWe   = 1'b1;
                bus.cfgAddr = 8'($urandom_range(0, 23));
                bus.cfgData = 16'($urandom);
            end
            step();
        end
        drain(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eq_tap_sequencer.md
# eq_tap_sequencer

Parametrised equalizer tap-coefficient sequencer. It holds a writable base-coefficient memory for `NUM_BANDS × TAPS_PER_BAND` taps. On a load request it captures a packed per-band gain word (`eqVal`) and streams every tap as a gain-scaled, saturated coefficient to the recursive filter datapath over a valid/ready handshake. It sits between the control/config interface and the filter's coefficient register file. It generalises the fixed 4-tap, 8-bit-eqVal tap fetcher with configurable band count, taps per band, coefficient width and gain resolution, backpressure, and load queuing.

## Interface
Parameters:
- `NUM_BANDS`, default 4: number of equalizer bands.
- `TAPS_PER_BAND`, default 4: taps per band. `NUM_TAPS = NUM_BANDS*TAPS_PER_BAND`, with `NUM_TAPS ≤ 256`.
- `COEFF_W`, default 16: signed coefficient width.
- `GAIN_W`, default 2: gain code width per band. Unity gain = `2^(GAIN_W-1)`.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `cfgWe`, in, 1: base-coefficient write strobe.
- `cfgAddr`, in, 8: tap index to write.
- `cfgData`, in, `COEFF_W`: signed base coefficient.
- `load`, in, 1: single-cycle request to start a sequence.
- `eqVal`, in, `NUM_BANDS*GAIN_W`: band b gain = `eqVal[b*GAIN_W +: GAIN_W]`, sampled only when `load` is high.
- `tapValid`, out, 1: `tapCoeff`/`tapNum`/`tapLast` are valid.
- `tapReady`, in, 1: downstream accepts the current tap.
- `tapCoeff`, out, `COEFF_W`: scaled coefficient.
- `tapNum`, out, 8: tap index, 0..NUM_TAPS-1.
- `tapLast`, out, 1: high with tap `NUM_TAPS-1`.
- `busy`, out, 1: sequence in progress or pending.

## Operation
- Memory: `NUM_TAPS` × `COEFF_W` synchronous-read RAM. It is not cleared by reset.
- Writes with `cfgAddr ≥ NUM_TAPS` are ignored.
- `cfgWe` is ignored while `busy`=1.
- FSM states:
  - IDLE: `load` → FETCH. eqVal is captured into the gain register, and the address is set to 0.
  - FETCH: one RAM read cycle → STREAM.
  - STREAM: holds the tap until accepted.
    - An accept (`tapValid & tapReady`) on a non-last tap advances to the next tap with no bubble.
    - An accept on the last tap goes to IDLE, or to FETCH if a load is pending.
- Scaling, for tap t:
  - Band: b = t / TAPS_PER_BAND.
  - `prod = base × {1'b0, gain_b}`, signed, `COEFF_W+GAIN_W+1` bits.
  - Result = `prod >>> (GAIN_W-1)`, arithmetic shift (floor).
  - The result saturates to [−2^(COEFF_W−1), 2^(COEFF_W−1)−1].
- Handshake:
  - Once `tapValid` rises, it and all payload hold stable until accepted.
  - `tapValid` never drops without an accept, except on reset.
- `load` while `busy`:
  - The request is queued as one pending request with its `eqVal`.
  - A further `load` overwrites the pending `eqVal`.
  - The current sequence always completes with its own captured gains.
- `load` in the same cycle as the last-tap accept becomes pending and starts immediately.
- `busy` = state ≠ IDLE, or pending.

## Timing
- Reset values: `tapValid`=0, `tapCoeff`=0, `tapNum`=0, `tapLast`=0, `busy`=0, pending cleared, state IDLE.
- Reset mid-sequence aborts immediately; no further taps are emitted.
- Latency and throughput:
  - `load` sampled at edge N: `busy`=1 after edge N, and first `tapValid` after edge N+2.
  - With `tapReady` held high, one tap per cycle: all NUM_TAPS taps appear in NUM_TAPS consecutive cycles.
  - `tapReady` low stalls with no loss or duplication.
- Completion:
  - After the last-tap accept at edge M, `tapValid`=0 and `busy`=0 from edge M (if no pending load).
  - If a load is pending, the next sequence's tap 0 is valid after edge M+2.
- Simultaneous `cfgWe` and `load` in IDLE: the write commits, then the sequence starts. The streamed tap 0 reflects that write if `cfgAddr`=0.

## Test plan
- Basic stream:
  - Stimulus: write base `{4,5,6,7}` to each band's taps 0..3 (16 taps). `load` with eqVal=8'hF4, gains band0=0, band1=1, band2=3, band3=3. `tapReady`=1.
  - Required: tapNum 0..15 in consecutive cycles.
  - tapCoeff: 0,0,0,0; 2,2,3,3; 6,7,9,10; 6,7,9,10.
  - `tapLast` only on tap 15.
  - First valid 2 cycles after `load`.
- Backpressure: same setup, toggle `tapReady` 1-0-0-1 pseudo-randomly → identical coefficient sequence, and payload stable while stalled.
- Saturation/rounding, gain 3 on band 0 with base 0x7000, 0x9000, 0xFFFB:
  - 0x7000 → 0x7FFF.
  - 0x9000 → 0x8000.
  - 0xFFFB → 0xFFF8 (−7.5 floors to −8).
  - With gain 1, 0xFFFB → 0xFFFD.
- Queued loads:
  - Stimulus: `load` F4, then during tap 5 `load` 8'hAA, then `load` 8'h55 during tap 9.
  - Required: first sequence completes with F4 gains; second starts 2 cycles after tap 15 is accepted, using 8'h55 (all gains 1: 2,2,3,3 pattern); 8'hAA is never used.
  - `busy` stays high throughout.
- Reset mid-stream: assert `reset` asynchronously during tap 7 → all outputs 0 immediately, then no taps until a new `load`.
- Config lockout: `cfgWe` to addr 3 with 0x1234 while `busy` → ignored, and the next sequence still shows the old value; a write to addr 20 in IDLE → no effect.
